nvme_host_en_seq: RTL and testbench
===================================

# nvme_host_en_seq

Controller enable sequencer for the NVMe host: an AXI-Lite master that drives the NVMe host slave register port (`host_s_axi_*`) after a start request. It performs one enable register write, then polls a status register until a ready mask is set, a retry limit is exhausted, or an error response is received. It sits between action control logic and `nvme_host`, sharing that port with nothing else while busy.

## Interface
- `ADDR_BITS`, default `` `HOST_ADDR_BITS ``: AXI-Lite address width.
- `ENABLE_ADDR`, default 'h14: address of the enable write.
- `ENABLE_DATA`, default 32'h0046_0001: data of the enable write. wstrb is always 4'hF.
- `POLL_ADDR`, default 'h1C: address of the status read.
- `POLL_MASK`, default 32'h1: ready when `(rdata & POLL_MASK) == POLL_MASK`.
- `MAX_POLLS`, default 1000: maximum number of status reads, ≥1.
- `POLL_GAP`, default 16: idle cycles between consecutive reads, ≥0.

Ports:
- `axi_aclk` in 1: single clock.
- `axi_aresetn` in 1: asynchronous, active-low reset.
- `start` in 1: level sampled in IDLE; starts a sequence.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: sticky success flag; cleared when a new sequence starts.
- `err` out 1: sticky failure flag; cleared when a new sequence starts.
- `err_code` out 2: 00 none, 01 bresp≠0, 10 poll timeout, 11 rresp≠0.
- `host_m_axi_awaddr` out ADDR_BITS; `host_m_axi_awvalid` out 1; `host_m_axi_awready` in 1.
- `host_m_axi_wdata` out 32; `host_m_axi_wstrb` out 4; `host_m_axi_wvalid` out 1; `host_m_axi_wready` in 1.
- `host_m_axi_bresp` in 2; `host_m_axi_bvalid` in 1; `host_m_axi_bready` out 1.
- `host_m_axi_araddr` out ADDR_BITS; `host_m_axi_arvalid` out 1; `host_m_axi_arready` in 1.
- `host_m_axi_rdata` in 32; `host_m_axi_rresp` in 2; `host_m_axi_rvalid` in 1; `host_m_axi_rready` out 1.

## Operation
- **States:** IDLE, WR, WRESP, RADDR, RDATA, GAP.
- **IDLE:** if `start` = 1, go to WR, clear `done`, `err`, `err_code`, and clear the poll counter.
- **WR:** awvalid and wvalid are both asserted. Each one deasserts after its own handshake. Move to WRESP once both handshakes have occurred; this may be the same cycle or in either order.
- **WRESP:** bready = 1. On bvalid:
  - bresp ≠ 0: `err` = 1, `err_code` = 01, go to IDLE (no polling).
  - otherwise: go to RADDR.
- **RADDR:** arvalid = 1. On arready, increment the poll counter and go to RDATA.
- **RDATA:** rready = 1. On rvalid:
  - rresp ≠ 0: `err` = 1, `err_code` = 11, go to IDLE.
  - mask matched: `done` = 1, go to IDLE.
  - poll counter == MAX_POLLS: `err` = 1, `err_code` = 10, go to IDLE.
  - otherwise: go to GAP, or directly to RADDR if POLL_GAP = 0.
- **GAP:** count POLL_GAP cycles, then go to RADDR.
- **Counter widths:** poll counter is $clog2(MAX_POLLS+1) bits; gap counter is $clog2(POLL_GAP+1) bits, minimum 1. Neither counter may wrap.
- **Constant outputs:** awaddr = ENABLE_ADDR, wdata = ENABLE_DATA, wstrb = 4'hF, araddr = POLL_ADDR.
- **`start` while busy:** ignored. `start` held high at completion launches a new sequence on the first IDLE cycle.

## Timing
- **Reset values:** all valid/ready outputs 0, `busy`/`done`/`err` 0, `err_code` 00, state IDLE. Address and data outputs hold their constant values.
- **Reset mid-operation:** asserting reset abandons any in-flight AXI transaction immediately. `nvme_host` shares the same reset.
- **Registered outputs:** all outputs are registered, with no combinational path from an input to an output.
- **Write issue:** awvalid and wvalid assert in the cycle after `start` is sampled in IDLE.
- **Flag timing:** `busy` rises in the cycle after `start` is sampled. `done`/`err` rise in the cycle after the deciding response handshake, in the same cycle that `busy` falls.
- **Valid stability:** a valid is never deasserted before its ready is seen.
- **Read spacing:** read-to-read spacing, from one rvalid handshake to the next arvalid, is POLL_GAP+1 cycles.
- **Minimum latency:** with all readies at 1 and the first read matching, `start` to `done` takes 5 cycles.

## Test plan
- **Zero-wait success:** all readies = 1, bresp = 0, first rdata = 1 → exactly one AW/W at 'h14 with data 32'h0046_0001; one AR at 'h1C; `done` = 1 at cycle 5; `err` = 0.
- **Late ready:** rdata = 0 for 3 reads, then 1; POLL_GAP = 16 → 4 reads, each 17 cycles apart; `done` = 1; `err_code` = 00.
- **Timeout:** rdata always 0, MAX_POLLS = 4 → exactly 4 reads; `err` = 1; `err_code` = 10; no fifth AR.
- **Write error:** bresp = 2'b10 → `err_code` = 01; no AR issued. A subsequent `start` clears `err` and reruns the sequence.
- **Split handshakes:** awready delayed 3 cycles, wready immediate → wvalid drops after 1 cycle and awvalid is held for 4 cycles; WRESP is entered only after both handshakes.
- **Reset mid-poll:** assert `axi_aresetn` = 0 while in RDATA → all outputs return to reset values asynchronously; no `done`/`err` after release; `start` restarts cleanly.

Source files
------------

// File: rtl/nvme_host_en_seq.sv
// nvme_host_en_seq: enables the NVMe host controller with one AXI-Lite write, then polls
// its status register until the ready mask matches, the poll budget runs out or a response errors.
`ifndef HOST_ADDR_BITS
`define HOST_ADDR_BITS 32
`endif
module nvme_host_en_seq #(
   parameter int                   ADDR_BITS   = `HOST_ADDR_BITS,
   parameter logic [ADDR_BITS-1:0] ENABLE_ADDR = 'h14,
   parameter logic [31:0]          ENABLE_DATA = 32'h0046_0001,
   parameter logic [ADDR_BITS-1:0] POLL_ADDR   = 'h1C,
   parameter logic [31:0]          POLL_MASK   = 32'h1,
   parameter int                   MAX_POLLS   = 1000,
   parameter int                   POLL_GAP    = 16
) (
   input  logic                 axi_aclk,
   input  logic                 axi_aresetn,
   input  logic                 start,
   output logic                 busy,
   output logic                 done,
   output logic                 err,
   output logic [1:0]           err_code,
   output logic [ADDR_BITS-1:0] host_m_axi_awaddr,
   output logic                 host_m_axi_awvalid,
   input  logic                 host_m_axi_awready,
   output logic [31:0]          host_m_axi_wdata,
   output logic [3:0]           host_m_axi_wstrb,
   output logic                 host_m_axi_wvalid,
   input  logic                 host_m_axi_wready,
   input  logic [1:0]           host_m_axi_bresp,
   input  logic                 host_m_axi_bvalid,
   output logic                 host_m_axi_bready,
   output logic [ADDR_BITS-1:0] host_m_axi_araddr,
   output logic                 host_m_axi_arvalid,
   input  logic                 host_m_axi_arready,
   input  logic [31:0]          host_m_axi_rdata,
   input  logic [1:0]           host_m_axi_rresp,
   input  logic                 host_m_axi_rvalid,
   output logic                 host_m_axi_rready
);
   localparam int PW = $clog2(MAX_POLLS + 1);
   localparam int GW = POLL_GAP > 0 ? $clog2(POLL_GAP + 1) : 1;
   localparam logic [PW-1:0] POLL_LAST = PW'(MAX_POLLS);
   localparam logic [GW-1:0] GAP_LAST = GW'(POLL_GAP > 0 ? POLL_GAP - 1 : 0);

   typedef enum logic [2:0] {IDLE, WR, WRESP, RADDR, RDATA, GAP} state_t;

   state_t        state, state_n;
   logic [PW-1:0] polls, polls_n;
   logic [GW-1:0] gap, gap_n;
   logic          aw_ok, aw_ok_n, w_ok, w_ok_n;
   logic          done_n, err_n;
   logic [1:0]    code_n;

   assign host_m_axi_awaddr = ENABLE_ADDR;
   assign host_m_axi_wdata  = ENABLE_DATA;
   assign host_m_axi_wstrb  = 4'hF;
   assign host_m_axi_araddr = POLL_ADDR;

   always_comb begin
      state_n = state;
      polls_n = polls;
      gap_n   = gap;
      aw_ok_n = aw_ok;
      w_ok_n  = w_ok;
      done_n  = done;
      err_n   = err;
      code_n  = err_code;
      case (state)
         IDLE: if (start) begin
            state_n = WR;
            polls_n = '0;
            aw_ok_n = 1'b0;
            w_ok_n  = 1'b0;
            done_n  = 1'b0;
            err_n   = 1'b0;
            code_n  = 2'b00;
         end
         WR: begin
            // AW and W complete independently; leave only once both have handshaken
            aw_ok_n = aw_ok | (host_m_axi_awvalid & host_m_axi_awready);
            w_ok_n  = w_ok | (host_m_axi_wvalid & host_m_axi_wready);
            if (aw_ok_n && w_ok_n) state_n = WRESP;
         end
         WRESP: if (host_m_axi_bvalid) begin
            if (host_m_axi_bresp != 2'b00) begin
               state_n = IDLE;
               err_n   = 1'b1;
               code_n  = 2'b01;
            end else state_n = RADDR;
         end
         RADDR: if (host_m_axi_arready) begin
            polls_n = polls + 1'b1;
            state_n = RDATA;
         end
         RDATA: if (host_m_axi_rvalid) begin
            if (host_m_axi_rresp != 2'b00) begin
               state_n = IDLE;
               err_n   = 1'b1;
               code_n  = 2'b11;
            end else if ((host_m_axi_rdata & POLL_MASK) == POLL_MASK) begin
               state_n = IDLE;
               done_n  = 1'b1;
            end else if (polls == POLL_LAST) begin
               state_n = IDLE;
               err_n   = 1'b1;
               code_n  = 2'b10;
            end else if (POLL_GAP == 0) state_n = RADDR;
            else begin
               state_n = GAP;
               gap_n   = '0;
            end
         end
         GAP: if (gap == GAP_LAST) state_n = RADDR;
              else gap_n = gap + 1'b1;
         default: state_n = IDLE;
      endcase
   end

   // Handshake outputs are registered from the next state so they line up with the state register
   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
         state              <= IDLE;
         polls              <= '0;
         gap                <= '0;
         aw_ok              <= 1'b0;
         w_ok               <= 1'b0;
         done               <= 1'b0;
         err                <= 1'b0;
         err_code           <= 2'b00;
         busy               <= 1'b0;
         host_m_axi_awvalid <= 1'b0;
         host_m_axi_wvalid  <= 1'b0;
         host_m_axi_bready  <= 1'b0;
         host_m_axi_arvalid <= 1'b0;
         host_m_axi_rready  <= 1'b0;
      end else begin
         state              <= state_n;
         polls              <= polls_n;
         gap                <= gap_n;
         aw_ok              <= aw_ok_n;
         w_ok               <= w_ok_n;
         done               <= done_n;
         err                <= err_n;
         err_code           <= code_n;
         busy               <= state_n != IDLE;
         host_m_axi_awvalid <= state_n == WR && !aw_ok_n;
         host_m_axi_wvalid  <= state_n == WR && !w_ok_n;
         host_m_axi_bready  <= state_n == WRESP;
         host_m_axi_arvalid <= state_n == RADDR;
         host_m_axi_rready  <= state_n == RDATA;
      end
   end
endmodule

// File: tb/tb_nvme_host_en_seq.sv
// tb_nvme_host_en_seq: randomized AXI-Lite slave around nvme_host_en_seq, with an
// outcome model derived from the response data and poll budget.
module tb_nvme_host_en_seq;
   localparam int AB   = 32;
   localparam int MAXP = 4;
   localparam int GAPC = 16;

   logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0;
   logic          busy, done, err;
   logic [1:0]    err_code;
   logic [AB-1:0] awaddr, araddr;
   logic [31:0]   wdata;
   logic [3:0]    wstrb;
   logic          awvalid, wvalid, bready, arvalid, rready;
   logic          awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
   logic [1:0]    bresp = 2'b00, rresp = 2'b00;
   logic [31:0]   rdata = 32'h0;

   nvme_host_en_seq #(.ADDR_BITS(AB), .MAX_POLLS(MAXP), .POLL_GAP(GAPC)) dut (
      .axi_aclk(clk), .axi_aresetn(rst_n), .start(start), .busy(busy), .done(done), .err(err),
      .err_code(err_code),
      .host_m_axi_awaddr(awaddr), .host_m_axi_awvalid(awvalid), .host_m_axi_awready(awready),
      .host_m_axi_wdata(wdata), .host_m_axi_wstrb(wstrb), .host_m_axi_wvalid(wvalid),
      .host_m_axi_wready(wready), .host_m_axi_bresp(bresp), .host_m_axi_bvalid(bvalid),
      .host_m_axi_bready(bready), .host_m_axi_araddr(araddr), .host_m_axi_arvalid(arvalid),
      .host_m_axi_arready(arready), .host_m_axi_rdata(rdata), .host_m_axi_rresp(rresp),
      .host_m_axi_rvalid(rvalid), .host_m_axi_rready(rready)
   );

   always #5 clk = ~clk;

   int n_chk = 0, n_fail = 0;
   int n = 0, aw_hs, w_hs, ar_hs, aw_hi, w_hi, stab_err = 0, aw_hs_n, w_hs_n, bready_rise_n;
   logic [AB-1:0] aw_addr_s, ar_addr_s;
   logic [31:0]   w_data_s;
   logic [3:0]    w_strb_s;
   int            r_hs_q[$], ar_rise_q[$];
   int            aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
   logic [1:0]    cfg_bresp = 2'b00;
   logic [31:0]   rd_q[$];
   logic [1:0]    rr_q[$];
   bit            aw_got, w_got, r_pend, b_hs, r_hs, aw_pend, w_pend, ar_pend, ar_prev, bready_prev;
   int            aw_wait, w_wait, ar_wait, b_wait, r_wait;

   // Slave and monitor: readies/responses are decided on the falling edge for the next rising edge
   initial forever begin
      @(negedge clk);
      n++;
      if (b_hs) bvalid = 1'b0;
      if (r_hs) rvalid = 1'b0;
      b_hs = 0;
      r_hs = 0;
      if (!rst_n) begin
         awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
         aw_got = 0; w_got = 0; r_pend = 0; aw_pend = 0; w_pend = 0; ar_pend = 0;
         ar_prev = 0; bready_prev = 0;
         aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
      end else begin
         if ((aw_pend && !awvalid) || (w_pend && !wvalid) || (ar_pend && !arvalid)) stab_err++;
         if (aw_got && w_got && !bvalid) begin
            if (b_wait >= b_dly) begin
               bvalid = 1; bresp = cfg_bresp; aw_got = 0; w_got = 0; b_wait = 0;
            end else b_wait++;
         end
         if (r_pend && !rvalid) begin
            if (r_wait >= r_dly) begin
               rvalid = 1;
               if (rd_q.size() > 0) rdata = rd_q.pop_front(); else rdata = 32'h0;
               if (rr_q.size() > 0) rresp = rr_q.pop_front(); else rresp = 2'b00;
               r_pend = 0; r_wait = 0;
            end else r_wait++;
         end
         awready = awvalid && aw_wait >= aw_dly;
         if (awvalid) aw_hi++;
         if (awvalid && !awready) aw_wait++;
         if (awready) begin aw_hs++; aw_hs_n = n; aw_addr_s = awaddr; aw_got = 1; aw_wait = 0; end
         aw_pend = awvalid && !awready;
         wready = wvalid && w_wait >= w_dly;
         if (wvalid) w_hi++;
         if (wvalid && !wready) w_wait++;
         if (wready) begin
            w_hs++; w_hs_n = n; w_data_s = wdata; w_strb_s = wstrb; w_got = 1; w_wait = 0;
         end
         w_pend = wvalid && !wready;
         if (arvalid && !ar_prev) ar_rise_q.push_back(n);
         ar_prev = arvalid;
         arready = arvalid && ar_wait >= ar_dly;
         if (arvalid && !arready) ar_wait++;
         if (arready) begin ar_hs++; ar_addr_s = araddr; r_pend = 1; ar_wait = 0; end
         ar_pend = arvalid && !arready;
         if (bready && !bready_prev) bready_rise_n = n;
         bready_prev = bready;
         b_hs = bvalid && bready;
         r_hs = rvalid && rready;
         if (r_hs) r_hs_q.push_back(n);
      end
   end

   task automatic clear_mon();
      aw_hs = 0; w_hs = 0; ar_hs = 0; aw_hi = 0; w_hi = 0;
      aw_hs_n = 0; w_hs_n = 0; bready_rise_n = 0;
      r_hs_q.delete(); ar_rise_q.delete(); rd_q.delete(); rr_q.delete();
   endtask

   task automatic set_dly(input int a, input int w, input int b, input int ar, input int r);
      aw_dly = a; w_dly = w; b_dly = b; ar_dly = ar; r_dly = r;
   endtask

   task automatic launch(output int t0);
      @(negedge clk); #1;
      start = 1'b1;
      t0 = n;
      @(negedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_idle(output bit ok);
      ok = 0;
      for (int i = 0; i < 2000; i++) begin
         if (!busy) begin ok = 1; break; end
         @(negedge clk); #1;
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      #1;
      n_chk++; if ({busy, done, err} !== 3'b000) begin n_fail++; $display("FAIL rst_flags: got %b expected 000", {busy, done, err}); end
      n_chk++; if (err_code !== 2'b00) begin n_fail++; $display("FAIL rst_code: got %b expected 00", err_code); end
      n_chk++; if ({awvalid, wvalid, bready, arvalid, rready} !== 5'b0) begin n_fail++; $display("FAIL rst_handshake: got %b expected 00000", {awvalid, wvalid, bready, arvalid, rready}); end
      n_chk++; if (awaddr !== 32'h14 || araddr !== 32'h1C) begin n_fail++; $display("FAIL rst_addr: got %h/%h expected 14/1c", awaddr, araddr); end
      n_chk++; if (wdata !== 32'h0046_0001 || wstrb !== 4'hF) begin n_fail++; $display("FAIL rst_wdata: got %h/%h expected 00460001/f", wdata, wstrb); end
      rst_n = 1'b1;
   endtask

   task automatic test_zero_wait();
      int t0;
      bit ok;
      clear_mon();
      set_dly(0, 0, 0, 0, 0);
      cfg_bresp = 2'b00;
      rd_q.push_back(32'h1);
      launch(t0);
      n_chk++; if ({busy, awvalid, wvalid} !== 3'b111) begin n_fail++; $display("FAIL zw_issue: got %b expected 111", {busy, awvalid, wvalid}); end
      repeat (3) @(negedge clk);
      #1;
      n_chk++; if ({done, busy} !== 2'b01) begin n_fail++; $display("FAIL zw_cycle4: got %b expected 01 at +%0d", {done, busy}, n - t0); end
      @(negedge clk); #1;
      n_chk++; if ({done, busy, err} !== 3'b100) begin n_fail++; $display("FAIL zw_cycle5: got %b expected 100 at +%0d", {done, busy, err}, n - t0); end
      wait_idle(ok);
      n_chk++; if (err_code !== 2'b00) begin n_fail++; $display("FAIL zw_code: got %b expected 00", err_code); end
      n_chk++; if (aw_hs !== 1 || w_hs !== 1) begin n_fail++; $display("FAIL zw_write_count: got %0d/%0d expected 1/1", aw_hs, w_hs); end
      n_chk++; if (aw_addr_s !== 32'h14) begin n_fail++; $display("FAIL zw_awaddr: got %h expected 14", aw_addr_s); end
      n_chk++; if (w_data_s !== 32'h0046_0001 || w_strb_s !== 4'hF) begin n_fail++; $display("FAIL zw_wdata: got %h/%h expected 00460001/f", w_data_s, w_strb_s); end
      n_chk++; if (ar_hs !== 1 || ar_addr_s !== 32'h1C) begin n_fail++; $display("FAIL zw_read: got %0d@%h expected 1@1c", ar_hs, ar_addr_s); end
   endtask

   task automatic test_late_ready();
      int t0;
      bit ok;
      clear_mon();
      set_dly($urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2));
      for (int i = 0; i < 3; i++) rd_q.push_back($urandom & 32'hFFFF_FFFE);
      rd_q.push_back($urandom | 32'h1);
      launch(t0);
      repeat (5) @(negedge clk);
      #1;
      start = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      start = 1'b0;
      wait_idle(ok);
      n_chk++; if (!ok) begin n_fail++; $display("FAIL late_wait: busy still %b after bound", busy); end
      n_chk++; if ({done, err, err_code} !== 4'b1000) begin n_fail++; $display("FAIL late_result: got %b expected 1000", {done, err, err_code}); end
      n_chk++; if (ar_hs !== 4 || aw_hs !== 1) begin n_fail++; $display("FAIL late_counts: got ar %0d aw %0d expected 4/1", ar_hs, aw_hs); end
      for (int i = 1; i < 4 && i < ar_rise_q.size() && i <= r_hs_q.size(); i++) begin
         n_chk++; if (ar_rise_q[i] - r_hs_q[i-1] !== GAPC + 1) begin n_fail++; $display("FAIL late_spacing%0d: got %0d expected %0d", i, ar_rise_q[i] - r_hs_q[i-1], GAPC + 1); end
      end
   endtask

   task automatic test_timeout();
      int t0, ar_at_end;
      bit ok;
      clear_mon();
      set_dly($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      launch(t0);
      wait_idle(ok);
      n_chk++; if (!ok) begin n_fail++; $display("FAIL to_wait: busy still %b after bound", busy); end
      n_chk++; if ({done, err, err_code} !== 4'b0110) begin n_fail++; $display("FAIL to_result: got %b expected 0110", {done, err, err_code}); end
      ar_at_end = ar_hs;
      n_chk++; if (ar_at_end !== MAXP) begin n_fail++; $display("FAIL to_reads: got %0d expected %0d", ar_at_end, MAXP); end
      repeat (40) @(negedge clk);
      #1;
      n_chk++; if (ar_hs !== MAXP || busy !== 1'b0) begin n_fail++; $display("FAIL to_no_extra: got ar %0d busy %b expected %0d/0", ar_hs, busy, MAXP); end
   endtask

   task automatic test_write_error();
      int t0;
      bit ok;
      clear_mon();
      set_dly(0, 1, 1, 0, 0);
      cfg_bresp = 2'b10;
      launch(t0);
      wait_idle(ok);
      n_chk++; if ({done, err, err_code} !== 4'b0101) begin n_fail++; $display("FAIL we_result: got %b expected 0101", {done, err, err_code}); end
      n_chk++; if (ar_hs !== 0) begin n_fail++; $display("FAIL we_no_read: got %0d expected 0", ar_hs); end
      clear_mon();
      cfg_bresp = 2'b00;
      rd_q.push_back(32'h1);
      launch(t0);
      n_chk++; if ({err, err_code, busy} !== 4'b0001) begin n_fail++; $display("FAIL we_clear: got %b expected 0001", {err, err_code, busy}); end
      wait_idle(ok);
      n_chk++; if ({done, err, ar_hs == 1} !== 3'b101) begin n_fail++; $display("FAIL we_rerun: got %b expected 101", {done, err, ar_hs == 1}); end
   endtask

   task automatic test_split();
      int t0;
      bit ok;
      clear_mon();
      set_dly(3, 0, 0, 0, 0);
      rd_q.push_back(32'h1);
      launch(t0);
      wait_idle(ok);
      n_chk++; if (aw_hi !== 4 || w_hi !== 1) begin n_fail++; $display("FAIL split_valid_len: got aw %0d w %0d expected 4/1", aw_hi, w_hi); end
      n_chk++; if (bready_rise_n !== aw_hs_n + 1) begin n_fail++; $display("FAIL split_wresp: got %0d expected %0d", bready_rise_n, aw_hs_n + 1); end
      n_chk++; if (done !== 1'b1) begin n_fail++; $display("FAIL split_done: got %b expected 1", done); end
   endtask

   task automatic test_reset_mid_poll();
      int t0, aw_before;
      bit ok, seen;
      clear_mon();
      set_dly(0, 0, 0, 0, 6);
      launch(t0);
      seen = 0;
      for (int i = 0; i < 50; i++) begin
         if (rready) begin seen = 1; break; end
         @(negedge clk); #1;
      end
      n_chk++; if (!seen) begin n_fail++; $display("FAIL rmp_reach_rdata: rready %b after bound", rready); end
      #2 rst_n = 1'b0;
      #1;
      n_chk++; if ({busy, done, err, err_code} !== 5'b0) begin n_fail++; $display("FAIL rmp_async_flags: got %b expected 00000", {busy, done, err, err_code}); end
      n_chk++; if ({awvalid, wvalid, bready, arvalid, rready} !== 5'b0) begin n_fail++; $display("FAIL rmp_async_hs: got %b expected 00000", {awvalid, wvalid, bready, arvalid, rready}); end
      @(negedge clk); #1;
      rst_n = 1'b1;
      set_dly(0, 0, 0, 0, 0);
      aw_before = aw_hs;
      repeat (30) @(negedge clk);
      #1;
      n_chk++; if ({busy, done, err} !== 3'b000 || aw_hs !== aw_before) begin n_fail++; $display("FAIL rmp_quiet: got %b aw %0d expected 000 aw %0d", {busy, done, err}, aw_hs, aw_before); end
      clear_mon();
      rd_q.push_back(32'h1);
      launch(t0);
      wait_idle(ok);
      n_chk++; if ({done, err, aw_hs == 1, ar_hs == 1} !== 4'b1011) begin n_fail++; $display("FAIL rmp_restart: got %b expected 1011", {done, err, aw_hs == 1, ar_hs == 1}); end
   endtask

   task automatic test_back_to_back();
      bit ok, seen;
      clear_mon();
      set_dly(0, 0, 0, 0, 0);
      rd_q.push_back(32'h1);
      rd_q.push_back(32'h3);
      @(negedge clk); #1;
      start = 1'b1;
      seen = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk); #1;
         if (done) begin seen = 1; break; end
      end
      n_chk++; if (!seen || busy !== 1'b0) begin n_fail++; $display("FAIL b2b_first: got done %b busy %b expected 1/0", seen, busy); end
      @(negedge clk); #1;
      start = 1'b0;
      n_chk++; if ({busy, done} !== 2'b10) begin n_fail++; $display("FAIL b2b_relaunch: got %b expected 10", {busy, done}); end
      wait_idle(ok);
      n_chk++; if ({done, aw_hs == 2, ar_hs == 2} !== 3'b111) begin n_fail++; $display("FAIL b2b_second: got %b expected 111 (aw %0d ar %0d)", {done, aw_hs == 2, ar_hs == 2}, aw_hs, ar_hs); end
   endtask

   task automatic test_random();
      logic [31:0] rd[8];
      logic [1:0]  rr[8], br, exp_code, d_rr;
      logic [31:0] d;
      int          nv, exp_reads, t0;
      bit          exp_done, ok;
      for (int it = 0; it < 10; it++) begin
         clear_mon();
         set_dly($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
         br = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         cfg_bresp = br;
         nv = $urandom_range(1, 6);
         for (int i = 0; i < nv; i++) begin
            rd[i] = ($urandom_range(0, 3) == 0) ? ($urandom | 32'h1) : ($urandom & 32'hFFFF_FFFE);
            rr[i] = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            rd_q.push_back(rd[i]);
            rr_q.push_back(rr[i]);
         end
         exp_code = 2'b00; exp_done = 0; exp_reads = 0;
         if (br != 2'b00) exp_code = 2'b01;
         else for (int i = 0; i < MAXP; i++) begin
            d = (i < nv) ? rd[i] : 32'h0;
            d_rr = (i < nv) ? rr[i] : 2'b00;
            exp_reads = i + 1;
            if (d_rr != 2'b00) begin exp_code = 2'b11; break; end
            if (d[0]) begin exp_done = 1; break; end
            if (i == MAXP - 1) exp_code = 2'b10;
         end
         launch(t0);
         wait_idle(ok);
         n_chk++; if (!ok) begin n_fail++; $display("FAIL rnd%0d_wait: busy still %b", it, busy); end
         n_chk++; if ({done, err, err_code} !== {exp_done, exp_code != 2'b00, exp_code}) begin n_fail++; $display("FAIL rnd%0d_result: got %b expected %b", it, {done, err, err_code}, {exp_done, exp_code != 2'b00, exp_code}); end
         n_chk++; if (ar_hs !== exp_reads) begin n_fail++; $display("FAIL rnd%0d_reads: got %0d expected %0d", it, ar_hs, exp_reads); end
      end
      cfg_bresp = 2'b00;
   endtask

   initial begin
      test_reset();
      test_zero_wait();
      test_late_ready();
      test_timeout();
      test_write_error();
      test_split();
      test_reset_mid_poll();
      test_back_to_back();
      test_random();
      n_chk++; if (stab_err !== 0) begin n_fail++; $display("FAIL valid_stability: got %0d drops expected 0", stab_err); end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
